alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; shift amount field is b[4:0].
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request strobe; sampled only while busy=0.
REQ-005 SHALL have port alu_op  input  4  operation code: 0000 ADD, 0001 SUB, 0010 SLT, 0011 SLTU, 0100 AND, 0101 OR, 0110 XOR, 1000 SLL, 1001 SRL, 1011 SRA.
REQ-006 SHALL have port a  input  WIDTH  first operand.
REQ-007 SHALL have port b  input  WIDTH  second operand or shift amount.
REQ-008 SHALL have port busy  output  1  high while a shift is iterating.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-010 SHALL have port result  output  WIDTH  registered result.
REQ-011 SHALL have port zero  output  1  registered flag, result==0.
REQ-012 SHALL have port illegal  output  1  registered flag, high with done when alu_op was not a listed code.

Function
REQ-013 SHALL implement FSM states IDLE and SHIFT; busy=1 exactly in SHIFT.
REQ-014 SHALL, in IDLE with start=1 at edge of cycle T, latch alu_op, a, b; inputs after T SHALL not affect the operation.
REQ-015 SHALL complete ADD, SUB, SLT, SLTU, AND, OR, XOR in one cycle: result, zero, illegal valid and done=1 in cycle T+1; FSM stays IDLE.
REQ-016 SHALL compute ADD/SUB modulo 2^WIDTH (carry/borrow discarded).
REQ-017 SHALL produce SLT = 1 if signed(a)<signed(b) else 0, SLTU = unsigned compare, zero-extended to WIDTH.
REQ-018 SHALL use only b[4:0] as shift amount n; upper b bits ignored.
REQ-019 SHALL, for shifts with n=0, produce result=a with done in cycle T+1, never entering SHIFT.
REQ-020 SHALL, for shifts with n>0, enter SHIFT in cycle T+1, shift the accumulator one bit per cycle for n cycles (T+1..T+n), return to IDLE and pulse done in cycle T+n+1; latency n+1.
REQ-021 SHALL fill SLL/SRL vacated bits with 0 and SRA vacated bits with the latched a[WIDTH-1].
REQ-022 SHALL, for unlisted alu_op codes (0111, 1010, 11xx), produce result=0, zero=1, illegal=1, done in cycle T+1.
REQ-023 SHALL ignore start while busy=1 (no queuing, no effect on operation in flight).
REQ-024 SHALL accept start in the same cycle done=1 (back-to-back, one result per cycle for single-cycle ops).
REQ-025 SHALL hold result, zero, illegal stable from a done pulse until the next done pulse.
REQ-026 SHALL keep done low in every cycle not matching REQ-015/019/020/022.

Reset
REQ-027 SHALL, when rstn=0 at a rising edge, set state=IDLE, busy=0, done=0, result=0, zero=1, illegal=0.
REQ-028 SHALL, on reset during SHIFT, abort the operation with no done pulse afterwards; start is ignored in any cycle rstn=0.

Verification
REQ-029 SHALL cover: SUB a=0x00000005 b=0x00000007 start at T -> done at T+1, result=0xFFFFFFFE, zero=0.
REQ-030 SHALL cover: SRA a=0x80000000 b=0x0000001F -> busy T+1..T+31, done at T+32, result=0xFFFFFFFF.
REQ-031 SHALL cover: SLT a=0xFFFFFFFF b=0x00000001 -> result=1; SLTU same operands -> result=0, zero=1.
REQ-032 SHALL cover: SLL a=0x1 b=0x00000023 (n=3) with start and changed a held high during busy -> done at T+4, result=0x8, extra starts ignored.
REQ-033 SHALL cover: alu_op=1010 -> done at T+1, illegal=1, result=0; then ADD 0x7FFFFFFF+1 started in that done cycle -> result=0x80000000 next cycle, illegal=0.
REQ-034 SHALL cover: rstn=0 for one cycle during SRL with n=10 -> busy=0 next cycle, no done pulse, result=0, zero=1.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: single-cycle arithmetic/logic ops plus shifts that iterate
// one bit per cycle. The shift amount comes from b[4:0]. The final result,
// the zero flag and the illegal flag are registered and only change on a
// done pulse.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  // Operation codes
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  // The shift kind is alu_op[1:0] of the three shift codes.
  localparam logic [1:0] SH_LL = 2'b00;
  localparam logic [1:0] SH_RL = 2'b01;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;       // working value of the shift in flight
  logic [4:0]       cnt;       // shift steps still to perform
  logic [1:0]       sh_kind;   // latched shift kind
  logic             sign;      // latched a[WIDTH-1], used as the SRA fill bit

  logic [WIDTH-1:0] imm_res;
  logic             imm_legal;
  logic             is_shift;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] acc_step;

  assign shamt = b[4:0];

  // Decode the live inputs. A shift with n=0 also finishes here, with result=a.
  always_comb begin
    imm_res   = '0;
    imm_legal = 1'b1;
    is_shift  = 1'b0;
    case (alu_op)
      OP_ADD:  imm_res = a + b;
      OP_SUB:  imm_res = a - b;
      OP_SLT:  imm_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: imm_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_AND:  imm_res = a & b;
      OP_OR:   imm_res = a | b;
      OP_XOR:  imm_res = a ^ b;
      OP_SLL, OP_SRL, OP_SRA: begin
        is_shift = 1'b1;
        imm_res  = a;
      end
      default: imm_legal = 1'b0;
    endcase
  end

  // Advance the accumulator by one bit position.
  always_comb begin
    acc_step = acc;
    case (sh_kind)
      SH_LL:   acc_step = {acc[WIDTH-2:0], 1'b0};
      SH_RL:   acc_step = {1'b0, acc[WIDTH-1:1]};
      default: acc_step = {sign, acc[WIDTH-1:1]};
    endcase
  end

  // Run the FSM. All outputs are registered. done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      sh_kind <= SH_LL;
      sign    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (is_shift && (shamt != 5'd0)) begin
              state   <= SHIFT;
              busy    <= 1'b1;
              acc     <= a;
              cnt     <= shamt;
              sh_kind <= alu_op[1:0];
              sign    <= a[WIDTH-1];
            end else begin
              done    <= 1'b1;
              result  <= imm_res;
              zero    <= (imm_res == '0);
              illegal <= ~imm_legal;
            end
          end
        end
        SHIFT: begin
          // start is ignored here. The operation in flight runs to completion.
          acc <= acc_step;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= acc_step;
            zero    <= (acc_step == '0);
            illegal <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle. It applies a table of directed vectors, then
// hand-written sequences for start held during busy, back-to-back after an
// illegal op, and reset during a shift.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [3:0]  alu_op;
  logic [31:0] a, b;
  logic        busy, done, zero, illegal;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .alu_op(alu_op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t tv[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle, then scramble the inputs and wait for done.
  // The wait is bounded.
  task automatic run_op(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        output int lat, output int bcnt);
    alu_op = op; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; alu_op = 4'($urandom);
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt;
    tv[0]  = '{4'b0001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 1};
    tv[1]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1};
    tv[2]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
    tv[3]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
    tv[4]  = '{4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
    tv[5]  = '{4'b0010, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1};
    tv[6]  = '{4'b0010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1};
    tv[7]  = '{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1};
    tv[8]  = '{4'b0101, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 1};
    tv[9]  = '{4'b0110, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 1};
    tv[10] = '{4'b1011, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 32};
    tv[11] = '{4'b1001, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 5};
    tv[12] = '{4'b1000, 32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 1'b0, 4};
    tv[13] = '{4'b1000, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, 1'b0, 1'b0, 1};
    tv[14] = '{4'b1011, 32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0, 1'b0, 5};
    tv[15] = '{4'b1010, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1};
    tv[16] = '{4'b0111, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1};
    tv[17] = '{4'b1100, 32'hFFFFFFFF, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1};
    tv[18] = '{4'b1111, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1};
    tv[19] = '{4'b0001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1};

    rstn = 1'b0; start = 1'b0; alu_op = 4'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 20; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, lat, bcnt);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(tv[i].lat - 1));
      chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_result", i), result, tv[i].res);
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(tv[i].z));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(tv[i].ill));
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_hold", i), result, tv[i].res);
    end

    // SLL n=3 with start held and inputs changed while busy. The held start
    // then launches the ADD in the done cycle.
    alu_op = 4'b1000; a = 32'h1; b = 32'h23; start = 1'b1;
    @(posedge clk); #1;
    alu_op = 4'b0000; a = 32'hFF; b = 32'h1;
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk("sll_hold_latency", 32'(lat), 32'd4);
    chk("sll_hold_busy", 32'(bcnt), 32'd3);
    chk("sll_hold_result", result, 32'h8);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_add_done", 32'(done), 32'd1);
    chk("b2b_add_result", result, 32'h100);
    @(posedge clk); #1;
    chk("b2b_add_done_low", 32'(done), 32'd0);

    // Illegal op, then ADD started in the done cycle
    alu_op = 4'b1010; a = 32'h5; b = 32'h6; start = 1'b1;
    @(posedge clk); #1;
    chk("ill_done", 32'(done), 32'd1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_result", result, 32'd0);
    alu_op = 4'b0000; a = 32'h7FFFFFFF; b = 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ill_add_done", 32'(done), 32'd1);
    chk("ill_add_result", result, 32'h80000000);
    chk("ill_add_illegal", 32'(illegal), 32'd0);
    chk("ill_add_zero", 32'(zero), 32'd0);

    // Reset during SRL n=10 aborts with no done. start is ignored while in reset.
    alu_op = 4'b1001; a = 32'hFFFFFFFF; b = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("srl_busy_before_rst", 32'(busy), 32'd1);
    rstn = 1'b0; start = 1'b1; alu_op = 4'b0000; a = 32'h1; b = 32'h1;
    @(posedge clk); #1;
    rstn = 1'b1; start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    begin
      int seen = 0;
      for (int k = 0; k < 15; k++) begin
        @(posedge clk); #1;
        if (done || busy) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
